// File: rtl/rs_issue_sched_if.sv
// Dispatch, CDB, issue and status signals of the reservation-station scheduler.
// The master side (dispatch/CDB/ALU environment) drives requests; the slave is the scheduler.
interface rs_issue_sched_if #(
    parameter int IDX_W = 4,
    parameter int ROB_W = 4
);
    logic             rdy_in;
    logic             flush;
    logic             alloc_valid;
    logic             alloc_r1;
    logic [ROB_W-1:0] alloc_q1;
    logic             alloc_r2;
    logic [ROB_W-1:0] alloc_q2;
    logic             cdb0_valid;
    logic [ROB_W-1:0] cdb0_tag;
    logic             cdb1_valid;
    logic [ROB_W-1:0] cdb1_tag;
    logic             issue_stall;
    logic [IDX_W-1:0] put_idx;
    logic             full;
    logic             ready;
    logic [IDX_W-1:0] ready_idx;
    logic [IDX_W:0]   count;

    modport master (
        output rdy_in, flush, alloc_valid, alloc_r1, alloc_q1, alloc_r2, alloc_q2,
               cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag, issue_stall,
        input  put_idx, full, ready, ready_idx, count
    );

    modport slave (
        input  rdy_in, flush, alloc_valid, alloc_r1, alloc_q1, alloc_r2, alloc_q2,
               cdb0_valid, cdb0_tag, cdb1_valid, cdb1_tag, issue_stall,
        output put_idx, full, ready, ready_idx, count
    );
endinterface

// File: rtl/rs_issue_sched.sv
// Reservation-station allocation and issue scheduler: tracks occupancy and pending
// operand tags, wakes entries from two CDB ports and issues the lowest ready entry.
module rs_issue_sched #(
    parameter int RS_SIZE = 16,
    parameter int IDX_W   = 4,
    parameter int ROB_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    rs_issue_sched_if.slave  rs
);
    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] p1;
    logic [RS_SIZE-1:0] p2;
    logic [ROB_W-1:0]   t1 [RS_SIZE];
    logic [ROB_W-1:0]   t2 [RS_SIZE];
    logic [IDX_W:0]     count_q;

    logic [RS_SIZE-1:0] eligible;
    logic [IDX_W-1:0]   put_sel;
    logic [IDX_W-1:0]   iss_sel;
    logic               full;
    logic               issue;
    logic               alloc_go;
    logic               alloc_p1;
    logic               alloc_p2;

    assign eligible = busy & ~p1 & ~p2;
    assign full     = &busy;

    // Descending scan so the last hit, i.e. the lowest index, wins.
    always_comb begin
        put_sel = '0;
        iss_sel = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])    put_sel = IDX_W'(i);
            if (eligible[i]) iss_sel = IDX_W'(i);
        end
    end

    assign issue    = rs.rdy_in & ~rs.issue_stall & ~rs.flush & ~rst_in & (|eligible);
    assign alloc_go = rs.alloc_valid & ~full & rs.rdy_in & ~rs.flush;

    // A broadcast in the dispatch cycle must be captured, or the entry would wait forever.
    assign alloc_p1 = ~rs.alloc_r1
                    & ~(rs.cdb0_valid && rs.cdb0_tag == rs.alloc_q1)
                    & ~(rs.cdb1_valid && rs.cdb1_tag == rs.alloc_q1);
    assign alloc_p2 = ~rs.alloc_r2
                    & ~(rs.cdb0_valid && rs.cdb0_tag == rs.alloc_q2)
                    & ~(rs.cdb1_valid && rs.cdb1_tag == rs.alloc_q2);

    assign rs.put_idx   = full ? '0 : put_sel;
    assign rs.full      = full;
    assign rs.ready     = issue;
    assign rs.ready_idx = issue ? iss_sel : '0;
    assign rs.count     = count_q;

    // NOTE: non-blocking assignments throughout; later writes to the same entry
    // (issue, then alloc) win, and put_idx never equals ready_idx, so they never collide.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy    <= '0;
            p1      <= '0;
            p2      <= '0;
            count_q <= '0;
            // NOTE: the tag arrays are reset explicitly because reset must zero all tags;
            // otherwise they would be left unreset, as their contents are masked by busy.
            for (int i = 0; i < RS_SIZE; i++) begin
                t1[i] <= '0;
                t2[i] <= '0;
            end
        end else if (rs.rdy_in) begin
            if (rs.flush) begin
                busy    <= '0;
                p1      <= '0;
                p2      <= '0;
                count_q <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        if ((rs.cdb0_valid && rs.cdb0_tag == t1[i]) ||
                            (rs.cdb1_valid && rs.cdb1_tag == t1[i]))
                            p1[i] <= 1'b0;
                        if ((rs.cdb0_valid && rs.cdb0_tag == t2[i]) ||
                            (rs.cdb1_valid && rs.cdb1_tag == t2[i]))
                            p2[i] <= 1'b0;
                    end
                end

                if (issue)
                    busy[iss_sel] <= 1'b0;

                if (alloc_go) begin
                    busy[put_sel] <= 1'b1;
                    p1[put_sel]   <= alloc_p1;
                    p2[put_sel]   <= alloc_p2;
                    t1[put_sel]   <= rs.alloc_q1;
                    t2[put_sel]   <= rs.alloc_q2;
                end

                case ({alloc_go, issue})
                    2'b10:   count_q <= count_q + (IDX_W+1)'(1);
                    2'b01:   count_q <= count_q - (IDX_W+1)'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed bench for rs_issue_sched: fill, wakeup, bypass, priority/reuse, flush,
// freeze and mid-run reset, with hand-computed expectations.
module tb_rs_issue_sched;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   proto_err = 0;

    rs_issue_sched_if bus ();

    rs_issue_sched dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rs     (bus)
    );

    always #5 clk_in = ~clk_in;

    // Dispatch protocol monitor: an alloc presented while the station is full is an error.
    always @(negedge clk_in) begin
        if (!rst_in && bus.rdy_in && !bus.flush && bus.alloc_valid && bus.full) begin
            proto_err++;
            $display("note: dispatch alloc while full at %0t", $time);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.rdy_in      = 1'b1;
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_r1    = 1'b1;
        bus.alloc_q1    = '0;
        bus.alloc_r2    = 1'b1;
        bus.alloc_q2    = '0;
        bus.cdb0_valid  = 1'b0;
        bus.cdb0_tag    = '0;
        bus.cdb1_valid  = 1'b0;
        bus.cdb1_tag    = '0;
        bus.issue_stall = 1'b0;
    endtask

    task automatic alloc(input logic r1, input logic [3:0] q1, input logic r2, input logic [3:0] q2);
        bus.alloc_valid = 1'b1;
        bus.alloc_r1    = r1;
        bus.alloc_q1    = q1;
        bus.alloc_r2    = r2;
        bus.alloc_q2    = q2;
    endtask

    task automatic do_reset();
        idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        settle();
        check("rst_put_idx", bus.put_idx, 0);
        check("rst_full", bus.full, 0);
        check("rst_ready", bus.ready, 0);
        check("rst_ready_idx", bus.ready_idx, 0);
        check("rst_count", bus.count, 0);

        // Fill all 16 entries with issue stalled
        bus.issue_stall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            alloc(1'b1, 4'd0, 1'b1, 4'd0);
            settle();
            check($sformatf("fill_put_idx_%0d", k), bus.put_idx, k);
            tick();
        end
        settle();
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 16);
        check("fill_put_forced0", bus.put_idx, 0);
        check("fill_stall_ready", bus.ready, 0);
        tick();                         // 17th alloc_valid, still asserted
        bus.alloc_valid = 1'b0;
        settle();
        check("over_count", bus.count, 16);
        check("over_full", bus.full, 1);
        check("over_proto_flag", proto_err, 1);
        bus.issue_stall = 1'b0;
        settle();
        check("full_issue_ready", bus.ready, 1);
        check("full_issue_idx", bus.ready_idx, 0);

        // Wakeup via cdb0 in cycle 3
        do_reset();
        alloc(1'b0, 4'd5, 1'b1, 4'd0);  // cycle 1
        settle();
        check("wk_c1_ready", bus.ready, 0);
        tick();
        idle();                         // cycle 2, unrelated broadcast
        bus.cdb1_valid = 1'b1;
        bus.cdb1_tag   = 4'd4;
        settle();
        check("wk_c2_ready", bus.ready, 0);
        check("wk_c2_count", bus.count, 1);
        tick();
        idle();                         // cycle 3
        bus.cdb0_valid = 1'b1;
        bus.cdb0_tag   = 4'd5;
        settle();
        check("wk_c3_ready", bus.ready, 0);
        tick();
        idle();                         // cycle 4
        settle();
        check("wk_c4_ready", bus.ready, 1);
        check("wk_c4_idx", bus.ready_idx, 0);
        tick();
        settle();
        check("wk_c5_count", bus.count, 0);
        check("wk_c5_ready", bus.ready, 0);

        // Same-cycle bypass on operand 2 via cdb1
        alloc(1'b1, 4'd0, 1'b0, 4'd7);
        bus.cdb1_valid = 1'b1;
        bus.cdb1_tag   = 4'd7;
        settle();
        check("byp_put_idx", bus.put_idx, 0);
        tick();
        idle();
        settle();
        check("byp_ready", bus.ready, 1);
        check("byp_idx", bus.ready_idx, 0);
        tick();
        settle();
        check("byp_count", bus.count, 0);

        // Priority and reuse: entries 2 and 9 ready, others pending on tag 3
        do_reset();
        bus.issue_stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 2 || k == 9) alloc(1'b1, 4'd0, 1'b1, 4'd0);
            else                  alloc(1'b0, 4'd3, 1'b1, 4'd0);
            tick();
        end
        idle();
        settle();
        check("pri_count", bus.count, 10);
        check("pri_c1_ready", bus.ready, 1);
        check("pri_c1_idx", bus.ready_idx, 2);
        tick();
        alloc(1'b0, 4'd3, 1'b1, 4'd0);  // concurrent alloc and issue
        settle();
        check("pri_c2_idx", bus.ready_idx, 9);
        check("pri_c2_put", bus.put_idx, 2);
        check("pri_c2_count", bus.count, 9);
        tick();
        idle();
        settle();
        check("pri_c3_count", bus.count, 9);
        check("pri_c3_ready", bus.ready, 0);
        check("pri_c3_put", bus.put_idx, 9);

        // Flush with 10 busy entries, all woken so issue would otherwise fire
        alloc(1'b0, 4'd3, 1'b1, 4'd0);
        tick();
        idle();
        bus.issue_stall = 1'b1;
        bus.cdb0_valid  = 1'b1;
        bus.cdb0_tag    = 4'd3;
        settle();
        check("fl_pre_count", bus.count, 10);
        tick();
        idle();
        bus.flush = 1'b1;
        alloc(1'b1, 4'd0, 1'b1, 4'd0);
        bus.cdb0_valid = 1'b1;
        bus.cdb0_tag   = 4'd3;
        settle();
        check("fl_same_ready", bus.ready, 0);
        tick();
        idle();
        settle();
        check("fl_count", bus.count, 0);
        check("fl_ready", bus.ready, 0);
        check("fl_put", bus.put_idx, 0);
        check("fl_full", bus.full, 0);

        // Freeze: rdy_in low for 5 cycles with an eligible entry
        alloc(1'b1, 4'd0, 1'b1, 4'd0);
        tick();
        idle();
        bus.rdy_in = 1'b0;
        alloc(1'b1, 4'd0, 1'b1, 4'd0);
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("frz_ready_%0d", k), bus.ready, 0);
            check($sformatf("frz_count_%0d", k), bus.count, 1);
            tick();
        end
        idle();
        settle();
        check("frz_resume_ready", bus.ready, 1);
        check("frz_resume_idx", bus.ready_idx, 0);
        tick();
        settle();
        check("frz_after_count", bus.count, 0);

        // Reset mid-operation with an eligible entry
        alloc(1'b1, 4'd0, 1'b1, 4'd0);
        tick();
        idle();
        rst_in = 1'b1;
        settle();
        check("mrst_same_ready", bus.ready, 0);
        tick();
        rst_in = 1'b0;
        settle();
        check("mrst_count", bus.count, 0);
        check("mrst_ready", bus.ready, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
